// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, types and S-box math for the AES-128
// key expander. Build macro AES_KEYEXP_COMB_SBOX_EN selects comb S-box.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] rk_t;
  typedef rk_t rk_tbl_t [0:NR];

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    XOR,
    DONE
  } ks_state_t;

  // Rcon table, top byte of the round constant word, rounds 1..10.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (b^127 by square-and-multiply, then one square),
  // followed by the affine map. b=0 falls out as 0 -> 8'h63.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), b);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: one AES S-box. Registered (block-RAM style) by default,
// combinational with AES_KEYEXP_COMB_SBOX_EN. Ports: clk, din, dout.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);

`ifdef AES_KEYEXP_COMB_SBOX_EN
  wire unused_clk = clk;
  assign dout = sub_byte(din);
`else
  // ROM-style read register: no reset so it maps onto a RAM output reg.
  always_ff @(posedge clk)
    dout <= sub_byte(din);
`endif

endmodule

// File: rtl/keyexp_step.sv
// keyexp_step: one AES-128 key-schedule round (RotWord, SubWord, Rcon,
// chained XOR). Ports: clk, prev (round key i-1), rcon, nxt (round key i).
module keyexp_step
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic [127:0] prev,
  input  logic [7:0]   rcon,
  output logic [127:0] nxt
);

  logic [31:0] w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t0, t1, t2, t3;

  assign w3  = prev[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sb (
      .clk  (clk),
      .din  (rot[8*g +: 8]),
      .dout (sub[8*g +: 8])
    );
  end

  // prev and rcon are held stable by the caller across the S-box
  // latency, so the registered sub lines up with the XOR chain.
  assign t0  = prev[127:96] ^ sub ^ {rcon, 24'h0};
  assign t1  = prev[95:64] ^ t0;
  assign t2  = prev[63:32] ^ t1;
  assign t3  = w3 ^ t2;
  assign nxt = {t0, t1, t2, t3};

endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule into an 11 x 128 flop table.
// Ports: clk, reset (async high), start, key, busy, ready, rd_round,
// rd_key (comb read). Macro AES_KEYEXP_COMB_SBOX_EN: 1 round/cycle.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

`ifdef AES_KEYEXP_COMB_SBOX_EN
  localparam ks_state_t STEP = XOR;
`else
  localparam ks_state_t STEP = SUB;
`endif

  ks_state_t    state;
  logic [3:0]   round;
  rk_tbl_t      tbl;
  logic [127:0] prev;
  logic [127:0] nxt;

  always_comb begin
    prev = tbl[0];
    for (int i = 1; i < NR; i++)
      if (round == 4'(i + 1)) prev = tbl[i];
  end

  keyexp_step u_step (
    .clk  (clk),
    .prev (prev),
    .rcon (rcon_of(round)),
    .nxt  (nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      round <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      tbl   <= '{default: '0};
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            tbl[0] <= key;
            round  <= 4'd1;
            busy   <= 1'b1;
            ready  <= 1'b0;
            state  <= STEP;
          end
        end
        SUB: state <= XOR;
        XOR: begin
          for (int i = 1; i <= NR; i++)
            if (round == 4'(i)) tbl[i] <= nxt;
          if (round == 4'(NR)) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            round <= round + 4'd1;
            state <= STEP;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++)
      if (rd_round == 4'(i)) rd_key = tbl[i];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench for aes_key_expander with a
// word-level FIPS-197 reference model (log/antilog S-box).
module tb_aes_key_expander;

`ifdef AES_KEYEXP_COMB_SBOX_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 20;
`endif

  typedef logic [127:0] tbl_t [0:10];
  typedef struct {
    tbl_t t;
    int   rise;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   rd_round = '0;
  logic         busy;
  logic         ready;
  logic [127:0] rd_key;

  aes_key_expander dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .ready    (ready),
    .rd_round (rd_round),
    .rd_key   (rd_key)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   zreq = 0;
  exp_t q[$];
  logic [7:0] sb [0:255];

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic void build_sbox();
    logic [7:0] ex [0:255];
    logic [7:0] lg [0:255];
    logic [7:0] v, inv, s;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = v;
      lg[v] = 8'(i);
      v = xt(v) ^ v;
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8]
             ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8];
      sb[x] = s ^ 8'h63;
    end
  endfunction

  function automatic tbl_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    tbl_t        rk;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge: start is sampled on the following posedge.
  task automatic issue(input logic [127:0] k,
                       input int ka, input logic [127:0] va,
                       input int kb, input logic [127:0] vb);
    exp_t e;
    e.t = expand(k);
    if (ka >= 0) e.t[ka] = va;
    if (kb >= 0) e.t[kb] = vb;
    e.rise = cyc + 1 + LAT;
    q.push_back(e);
    key   = k;
    start = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3*LAT + 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: %0d pending, want 0", q.size());
    q.delete();
  endtask

  // Monitor: checks every rising ready against the scoreboard head.
  initial begin
    int   bcnt;
    int   zdone;
    bit   pr;
    exp_t e;
    bcnt  = 0;
    zdone = 0;
    pr    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) bcnt = 0;
      else if (busy) bcnt++;
      if (zreq != zdone) begin
        zdone = zreq;
        chk("zero_busy", 128'(busy), 128'(0));
        chk("zero_ready", 128'(ready), 128'(0));
        for (int r = 0; r < 16; r++) begin
          rd_round = 4'(r);
          #1;
          chk($sformatf("zero_key[%0d]", r), rd_key, 128'(0));
        end
      end
      if (ready && !pr) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready: got ready=1 want 0");
        end else begin
          e = q.pop_front();
          chk("latency", 128'(cyc), 128'(e.rise));
          chk("busy_len", 128'(bcnt), 128'(LAT));
          chk("busy_done", 128'(busy), 128'(0));
          for (int r = 0; r < 16; r++) begin
            rd_round = 4'(r);
            #1;
            chk($sformatf("rk[%0d]", r), rd_key,
                (r <= 10) ? e.t[r] : 128'(0));
          end
        end
        bcnt = 0;
      end else if (q.size() > 0 && cyc > q[0].rise + 2) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no ready by cycle %0d want %0d",
                 cyc, q[0].rise);
        void'(q.pop_front());
      end
      pr = ready;
    end
  end

  initial begin
    logic [127:0] k;
    int gap;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(ready), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    zreq++;
    repeat (2) @(negedge clk);

    issue(128'h2b7e151628aed2a6abf7158809cf4f3c,
          1, 128'ha0fafe1788542cb123a339392a6c7605,
          10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    issue(128'h000102030405060708090a0b0c0d0e0f,
          0, 128'h000102030405060708090a0b0c0d0e0f,
          10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // start held through the expansion, key changed mid-way
    issue(rnd128(), -1, '0, -1, '0);
    repeat (5) @(negedge clk);
    key = rnd128();
    repeat (LAT - 4) @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // reset mid-expansion
    issue(rnd128(), -1, '0, -1, '0);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ready", 128'(ready), 128'(0));
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    zreq++;
    repeat (2) @(negedge clk);
    issue(rnd128(), -1, '0, -1, '0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // restart from DONE
    issue(rnd128(), -1, '0, -1, '0);
    @(negedge clk);
    start = 1'b0;
    chk("restart_ready", 128'(ready), 128'(0));
    chk("restart_busy", 128'(busy), 128'(1));
    wait_done();

    for (int n = 0; n < 6; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap + 1) @(negedge clk);
      k = rnd128();
      issue(k, -1, '0, -1, '0);
      @(negedge clk);
      start = 1'b0;
      wait_done();
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
